btac_pred_queue: RTL and testbench
==================================

// Module: btac_pred_queue
// PURPOSE
// - In-order queue between fetch and the resolve stage. Fetch pushes up to two predictions per cycle (pc, taken, taddr, tsat).
// - The resolve stage pops one entry per resolved slot and supplies the actual outcome (jump, branch, addr, npc).
// - The queue emits the registered upd_* bundle that drives the predictor update port (upd_pc, upd_pred, upd_jump, upd_branch, upd_addr, upd_npc per lane).
// - Fetch stalls on the stall output.
// PARAMETERS
// - DEPTH  8  entries, power of two, >=4. Entry = {pc[31:0], taken, taddr[31:0], tsat[1:0]} = 67 bits.
// PORTS
// clock        in   1   clock, rising edge
// reset        in   1   synchronous, active-low
// clear        in   1   flush; dominates all other inputs
// push0/push1  in   1   fetch slot valid; slot 0 is older
// pc0/pc1      in   32  fetch pc per slot
// taken0/1     in   1   predicted taken per slot
// taddr0/1     in   32  predicted target per slot
// tsat0/1      in   2   counter value read at prediction
// stall        out  1   count > DEPTH-2, combinational from registered count
// res0/res1    in   1   resolve slot valid; slot 0 is older
// res_jump0/1  in   1   actually taken
// res_branch0/1 in  1   instruction is a conditional branch
// res_addr0/1  in   32  actual target
// res_npc0/1   in   32  fall-through pc
// res_pc0/1    in   32  pc of resolved instruction (checked only with macro)
// upd_valid0/1 out  1   update lane valid
// upd_pc0/1    out  32  entry pc
// upd_taken0/1 out  1   stored prediction
// upd_taddr0/1 out  32  stored prediction
// upd_tsat0/1  out  2   stored prediction
// upd_jump0/1, upd_branch0/1, upd_addr0/1, upd_npc0/1  out  1/1/32/32  resolved outcome, registered
// underrun     out  1   pulse: a resolve slot found the queue empty
// count        out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
// - Reset (reset==0 at posedge): wptr = rptr = count = 0; all upd_* = 0; underrun = 0; storage not cleared.
// - Compaction: valid push slots are written at wptr, wptr+1 in slot order; push1 alone goes to wptr. Resolve slots compact the same way.
// - Push: accepted only when stall==0 and clear==0. Pushes while stalled are dropped; fetch must hold them.
// - Pop: slot k pops the entry at rptr+k only if the entry was occupied at cycle start (k < count). Otherwise that lane stays invalid and underrun=1 next cycle.
// - Same-cycle push+pop: count_next = count + npush - npop. A push never feeds a pop in the same cycle (no bypass).
// - Wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full is detected via count==DEPTH, never by pointer equality.
// - Outputs: upd_* are registered, 1-cycle latency from res*.
//   - Invalid lanes drive all upd fields 0.
//   - upd_jump = res_jump, upd_branch = res_branch, upd_addr = res_addr, upd_npc = res_npc, copied verbatim. This block does no miss arithmetic.
// - clear==1: rptr = wptr = count = 0; pushes and resolves in that cycle ignored; next-cycle upd_valid0/1 = 0, upd_* = 0, underrun = 0.
// - Reset mid-operation behaves as clear and also zeroes outputs.
// - stall is never asserted during reset.
// CONFIGURATION
// - BTAC_PRED_QUEUE_CHECK_EN defined:
//   - each popped entry's pc is compared to res_pc of its slot.
//   - On mismatch the lane's upd_valid and all upd fields are 0, the entry is still popped, and output chk_err (1 bit, registered) pulses 1.
// - Not defined: res_pc0/1 are unused and chk_err is tied 0.
// TESTING
// - Reset, then push0 pc=0x100 taken=1 taddr=0x200 tsat=3; next cycle res0 jump=1 addr=0x200 -> following cycle upd_valid0=1, upd_pc0=0x100, upd_taddr0=0x200, upd_tsat0=3, upd_jump0=1; count back to 0.
// - Push two slots per cycle for 4 cycles (DEPTH=8) -> stall=1 once count=7..8; extra pushes dropped; count never exceeds 8.
// - Fill 6, pop 2 and push 2 each cycle for 10 cycles -> count stays 6; pcs emerge in push order across pointer wrap 7->0.
// - Count=1, res0=res1=1 -> upd_valid0=1, upd_valid1=0, underrun=1 next cycle.
// - Count=5 with clear=1 together with push0 and res0 -> count=0 next cycle, upd_valid0=0, no entry written.
// - Macro defined: pushed pc=0x100, res_pc0=0x104 -> upd_valid0=0, chk_err=1, count decremented.

Source files
------------

// File: rtl/btac_pred_queue.sv
// rtl/btac_pred_queue.sv - in-order fetch-to-resolve prediction queue; optional pc check under BTAC_PRED_QUEUE_CHECK_EN
module btac_pred_queue #(
   parameter int DEPTH = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      push0,
   input  logic                      push1,
   input  logic [31:0]               pc0,
   input  logic [31:0]               pc1,
   input  logic                      taken0,
   input  logic                      taken1,
   input  logic [31:0]               taddr0,
   input  logic [31:0]               taddr1,
   input  logic [1:0]                tsat0,
   input  logic [1:0]                tsat1,
   output logic                      stall,
   input  logic                      res0,
   input  logic                      res1,
   input  logic                      res_jump0,
   input  logic                      res_jump1,
   input  logic                      res_branch0,
   input  logic                      res_branch1,
   input  logic [31:0]               res_addr0,
   input  logic [31:0]               res_addr1,
   input  logic [31:0]               res_npc0,
   input  logic [31:0]               res_npc1,
   input  logic [31:0]               res_pc0,
   input  logic [31:0]               res_pc1,
   output logic                      upd_valid0,
   output logic                      upd_valid1,
   output logic [31:0]               upd_pc0,
   output logic [31:0]               upd_pc1,
   output logic                      upd_taken0,
   output logic                      upd_taken1,
   output logic [31:0]               upd_taddr0,
   output logic [31:0]               upd_taddr1,
   output logic [1:0]                upd_tsat0,
   output logic [1:0]                upd_tsat1,
   output logic                      upd_jump0,
   output logic                      upd_jump1,
   output logic                      upd_branch0,
   output logic                      upd_branch1,
   output logic [31:0]               upd_addr0,
   output logic [31:0]               upd_addr1,
   output logic [31:0]               upd_npc0,
   output logic [31:0]               upd_npc1,
   output logic                      underrun,
   output logic                      chk_err,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   mem_pc    [DEPTH];
   logic          mem_taken [DEPTH];
   logic [31:0]   mem_taddr [DEPTH];
   logic [1:0]    mem_tsat  [DEPTH];

   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count_q;

   logic          push_en;
   logic [AW-1:0] wr_addr0, wr_addr1, rd_addr0, rd_addr1;
   logic [CW-1:0] npush, npop;
   logic          hit0, hit1, ok0, ok1, mis0, mis1, under_next;

   assign count = count_q;
   // Stall leaves room for a full two-slot push
   assign stall = (count_q > CW'(DEPTH - 2));

   // Slot compaction, occupancy check at cycle start, and optional pc check
   always_comb begin
      push_en  = reset && !clear && !stall;
      wr_addr0 = wptr;
      wr_addr1 = wptr + AW'(push0);
      npush    = push_en ? (CW'(push0) + CW'(push1)) : '0;
      rd_addr0 = rptr;
      rd_addr1 = rptr + AW'(res0);
      hit0     = !clear && res0 && (count_q != '0);
      hit1     = !clear && res1 && (count_q > CW'(res0));
      npop     = CW'(hit0) + CW'(hit1);
      under_next = !clear && ((res0 && !hit0) || (res1 && !hit1));
`ifdef BTAC_PRED_QUEUE_CHECK_EN
      mis0     = hit0 && (mem_pc[rd_addr0] != res_pc0);
      mis1     = hit1 && (mem_pc[rd_addr1] != res_pc1);
`else
      mis0     = 1'b0;
      mis1     = 1'b0;
`endif
      ok0      = hit0 && !mis0;
      ok1      = hit1 && !mis1;
   end

`ifndef BTAC_PRED_QUEUE_CHECK_EN
   logic unused_res_pc;
   assign unused_res_pc = ^{res_pc0, res_pc1};
`endif

   // Entry storage; never reset, only written by accepted pushes
   always_ff @(posedge clock) begin
      if (push_en && push0) begin
         mem_pc[wr_addr0]    <= pc0;
         mem_taken[wr_addr0] <= taken0;
         mem_taddr[wr_addr0] <= taddr0;
         mem_tsat[wr_addr0]  <= tsat0;
      end
      if (push_en && push1) begin
         mem_pc[wr_addr1]    <= pc1;
         mem_taken[wr_addr1] <= taken1;
         mem_taddr[wr_addr1] <= taddr1;
         mem_tsat[wr_addr1]  <= tsat1;
      end
   end

   // Pointers and occupancy; full is tracked by count, not pointer equality
   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         wptr    <= '0;
         rptr    <= '0;
         count_q <= '0;
      end else begin
         wptr    <= wptr + AW'(npush);
         rptr    <= rptr + AW'(npop);
         count_q <= count_q + npush - npop;
      end
   end

   // Registered update bundle; invalid or mismatched lanes drive zeros
   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         {upd_valid0, upd_pc0, upd_taken0, upd_taddr0, upd_tsat0} <= '0;
         {upd_jump0, upd_branch0, upd_addr0, upd_npc0}             <= '0;
         {upd_valid1, upd_pc1, upd_taken1, upd_taddr1, upd_tsat1} <= '0;
         {upd_jump1, upd_branch1, upd_addr1, upd_npc1}             <= '0;
         underrun <= 1'b0;
         chk_err  <= 1'b0;
      end else begin
         upd_valid0  <= ok0;
         upd_pc0     <= ok0 ? mem_pc[rd_addr0]    : 32'h0;
         upd_taken0  <= ok0 ? mem_taken[rd_addr0] : 1'b0;
         upd_taddr0  <= ok0 ? mem_taddr[rd_addr0] : 32'h0;
         upd_tsat0   <= ok0 ? mem_tsat[rd_addr0]  : 2'b0;
         upd_jump0   <= ok0 ? res_jump0           : 1'b0;
         upd_branch0 <= ok0 ? res_branch0         : 1'b0;
         upd_addr0   <= ok0 ? res_addr0           : 32'h0;
         upd_npc0    <= ok0 ? res_npc0            : 32'h0;
         upd_valid1  <= ok1;
         upd_pc1     <= ok1 ? mem_pc[rd_addr1]    : 32'h0;
         upd_taken1  <= ok1 ? mem_taken[rd_addr1] : 1'b0;
         upd_taddr1  <= ok1 ? mem_taddr[rd_addr1] : 32'h0;
         upd_tsat1   <= ok1 ? mem_tsat[rd_addr1]  : 2'b0;
         upd_jump1   <= ok1 ? res_jump1           : 1'b0;
         upd_branch1 <= ok1 ? res_branch1         : 1'b0;
         upd_addr1   <= ok1 ? res_addr1           : 32'h0;
         upd_npc1    <= ok1 ? res_npc1            : 32'h0;
         underrun    <= under_next;
         chk_err     <= mis0 || mis1;
      end
   end
endmodule

// File: tb/tb_btac_pred_queue.sv
// tb/tb_btac_pred_queue.sv - directed self-checking bench for btac_pred_queue
module tb_btac_pred_queue;
   logic        clock = 1'b0;
   logic        reset, clear;
   logic        push0, push1, taken0, taken1;
   logic [31:0] pc0, pc1, taddr0, taddr1;
   logic [1:0]  tsat0, tsat1;
   logic        stall;
   logic        res0, res1, res_jump0, res_jump1, res_branch0, res_branch1;
   logic [31:0] res_addr0, res_addr1, res_npc0, res_npc1, res_pc0, res_pc1;
   logic        upd_valid0, upd_valid1, upd_taken0, upd_taken1;
   logic [31:0] upd_pc0, upd_pc1, upd_taddr0, upd_taddr1;
   logic [1:0]  upd_tsat0, upd_tsat1;
   logic        upd_jump0, upd_jump1, upd_branch0, upd_branch1;
   logic [31:0] upd_addr0, upd_addr1, upd_npc0, upd_npc1;
   logic        underrun, chk_err;
   logic [3:0]  count;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb[$];
   logic [31:0] e0, e1;

   always #5 clock = ~clock;

   btac_pred_queue #(.DEPTH(8)) dut (
      .clock(clock), .reset(reset), .clear(clear),
      .push0(push0), .push1(push1), .pc0(pc0), .pc1(pc1),
      .taken0(taken0), .taken1(taken1), .taddr0(taddr0), .taddr1(taddr1),
      .tsat0(tsat0), .tsat1(tsat1), .stall(stall),
      .res0(res0), .res1(res1), .res_jump0(res_jump0), .res_jump1(res_jump1),
      .res_branch0(res_branch0), .res_branch1(res_branch1),
      .res_addr0(res_addr0), .res_addr1(res_addr1),
      .res_npc0(res_npc0), .res_npc1(res_npc1),
      .res_pc0(res_pc0), .res_pc1(res_pc1),
      .upd_valid0(upd_valid0), .upd_valid1(upd_valid1),
      .upd_pc0(upd_pc0), .upd_pc1(upd_pc1),
      .upd_taken0(upd_taken0), .upd_taken1(upd_taken1),
      .upd_taddr0(upd_taddr0), .upd_taddr1(upd_taddr1),
      .upd_tsat0(upd_tsat0), .upd_tsat1(upd_tsat1),
      .upd_jump0(upd_jump0), .upd_jump1(upd_jump1),
      .upd_branch0(upd_branch0), .upd_branch1(upd_branch1),
      .upd_addr0(upd_addr0), .upd_addr1(upd_addr1),
      .upd_npc0(upd_npc0), .upd_npc1(upd_npc1),
      .underrun(underrun), .chk_err(chk_err), .count(count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      clear = 0; push0 = 0; push1 = 0; res0 = 0; res1 = 0;
      pc0 = 0; pc1 = 0; taken0 = 0; taken1 = 0; taddr0 = 0; taddr1 = 0;
      tsat0 = 0; tsat1 = 0; res_jump0 = 0; res_jump1 = 0;
      res_branch0 = 0; res_branch1 = 0; res_addr0 = 0; res_addr1 = 0;
      res_npc0 = 0; res_npc1 = 0; res_pc0 = 0; res_pc1 = 0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic drive_push2(input logic [31:0] a, input logic [31:0] b);
      push0 = 1; pc0 = a; taken0 = 1; taddr0 = a + 32'h40; tsat0 = 2'd2;
      push1 = 1; pc1 = b; taken1 = 0; taddr1 = b + 32'h40; tsat1 = 2'd1;
   endtask

   task automatic drive_pop2(input logic [31:0] a, input logic [31:0] b);
      res0 = 1; res_pc0 = a; res_npc0 = a + 4;
      res1 = 1; res_pc1 = b; res_npc1 = b + 4;
   endtask

   initial begin
      idle();
      reset = 0;
      step(); step();
      chk("rst_count", 32'(count), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_v0", 32'(upd_valid0), 0);
      chk("rst_v1", 32'(upd_valid1), 0);
      chk("rst_underrun", 32'(underrun), 0);
      chk("rst_chk_err", 32'(chk_err), 0);
      reset = 1;

      // single push then resolve
      push0 = 1; pc0 = 32'h100; taken0 = 1; taddr0 = 32'h200; tsat0 = 2'd3;
      step();
      chk("one_count", 32'(count), 1);
      chk("one_v0_early", 32'(upd_valid0), 0);
      res0 = 1; res_jump0 = 1; res_branch0 = 1; res_addr0 = 32'h200;
      res_npc0 = 32'h104; res_pc0 = 32'h100;
      step();
      chk("one_v0", 32'(upd_valid0), 1);
      chk("one_pc0", upd_pc0, 32'h100);
      chk("one_taken0", 32'(upd_taken0), 1);
      chk("one_taddr0", upd_taddr0, 32'h200);
      chk("one_tsat0", 32'(upd_tsat0), 3);
      chk("one_jump0", 32'(upd_jump0), 1);
      chk("one_branch0", 32'(upd_branch0), 1);
      chk("one_addr0", upd_addr0, 32'h200);
      chk("one_npc0", upd_npc0, 32'h104);
      chk("one_v1", 32'(upd_valid1), 0);
      chk("one_count_after", 32'(count), 0);
      step();
      chk("idle_v0", 32'(upd_valid0), 0);
      chk("idle_addr0", upd_addr0, 0);

      // fill to full, two per cycle
      for (int i = 0; i < 4; i++) begin
         chk("fill_stall_pre", 32'(stall), 0);
         drive_push2(32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i));
         sb.push_back(32'h1000 + 32'(8 * i));
         sb.push_back(32'h1004 + 32'(8 * i));
         step();
         chk("fill_count", 32'(count), 32'(2 * (i + 1)));
      end
      chk("full_stall", 32'(stall), 1);
      drive_push2(32'hdead0, 32'hdead4);
      step();
      chk("drop_count", 32'(count), 8);

      // drain to 6
      e0 = sb.pop_front(); e1 = sb.pop_front();
      drive_pop2(e0, e1);
      step();
      chk("drain_pc0", upd_pc0, e0);
      chk("drain_pc1", upd_pc1, e1);
      chk("drain_npc1", upd_npc1, e1 + 4);
      chk("drain_count", 32'(count), 6);
      chk("drain_stall", 32'(stall), 0);

      // steady state across pointer wrap
      for (int i = 0; i < 10; i++) begin
         e0 = sb.pop_front(); e1 = sb.pop_front();
         drive_pop2(e0, e1);
         drive_push2(32'h2000 + 32'(8 * i), 32'h2004 + 32'(8 * i));
         sb.push_back(32'h2000 + 32'(8 * i));
         sb.push_back(32'h2004 + 32'(8 * i));
         step();
         chk("ss_v0", 32'(upd_valid0), 1);
         chk("ss_pc0", upd_pc0, e0);
         chk("ss_pc1", upd_pc1, e1);
         chk("ss_count", 32'(count), 6);
      end
      for (int i = 0; i < 3; i++) begin
         e0 = sb.pop_front(); e1 = sb.pop_front();
         drive_pop2(e0, e1);
         step();
         chk("tail_pc0", upd_pc0, e0);
         chk("tail_pc1", upd_pc1, e1);
         chk("tail_taddr1", upd_taddr1, e1 + 32'h40);
      end
      chk("tail_count", 32'(count), 0);

      // underrun on second slot
      push0 = 1; pc0 = 32'h300;
      step();
      drive_pop2(32'h300, 32'h304);
      step();
      chk("ur_v0", 32'(upd_valid0), 1);
      chk("ur_pc0", upd_pc0, 32'h300);
      chk("ur_v1", 32'(upd_valid1), 0);
      chk("ur_pc1", upd_pc1, 0);
      chk("ur_flag", 32'(underrun), 1);
      chk("ur_count", 32'(count), 0);
      step();
      chk("ur_pulse_end", 32'(underrun), 0);

      // clear dominates push and resolve
      drive_push2(32'h600, 32'h604); step();
      drive_push2(32'h608, 32'h60c); step();
      push0 = 1; pc0 = 32'h610; step();
      chk("pre_clear_count", 32'(count), 5);
      clear = 1; push0 = 1; pc0 = 32'h999; res0 = 1; res_pc0 = 32'h600;
      step();
      chk("clr_count", 32'(count), 0);
      chk("clr_v0", 32'(upd_valid0), 0);
      chk("clr_pc0", upd_pc0, 0);
      chk("clr_underrun", 32'(underrun), 0);
      res0 = 1; res_pc0 = 32'h999;
      step();
      chk("clr_empty_v0", 32'(upd_valid0), 0);
      chk("clr_empty_ur", 32'(underrun), 1);
      chk("clr_empty_count", 32'(count), 0);
      push0 = 1; pc0 = 32'h400; step();
      res0 = 1; res_pc0 = 32'h400; step();
      chk("post_clr_pc0", upd_pc0, 32'h400);
      chk("post_clr_count", 32'(count), 0);

      // lone slot 1 push and resolve compact to the head
      push1 = 1; pc1 = 32'h500; taddr1 = 32'h540; step();
      chk("p1_count", 32'(count), 1);
      res1 = 1; res_pc1 = 32'h500; res_addr1 = 32'h77; step();
      chk("p1_v1", 32'(upd_valid1), 1);
      chk("p1_pc1", upd_pc1, 32'h500);
      chk("p1_taddr1", upd_taddr1, 32'h540);
      chk("p1_addr1", upd_addr1, 32'h77);
      chk("p1_v0", 32'(upd_valid0), 0);
      chk("p1_ur", 32'(underrun), 0);

      // reset mid-operation
      drive_push2(32'h700, 32'h704); step();
      chk("mid_count", 32'(count), 2);
      reset = 0; res0 = 1; res_pc0 = 32'h700;
      step();
      chk("midrst_count", 32'(count), 0);
      chk("midrst_v0", 32'(upd_valid0), 0);
      chk("midrst_pc0", upd_pc0, 0);
      chk("midrst_stall", 32'(stall), 0);
      reset = 1;

      // pc check on a mismatched resolve
      push0 = 1; pc0 = 32'h100; step();
      res0 = 1; res_pc0 = 32'h104; res_jump0 = 1; res_addr0 = 32'h200; step();
`ifdef BTAC_PRED_QUEUE_CHECK_EN
      chk("chk_v0", 32'(upd_valid0), 0);
      chk("chk_jump0", 32'(upd_jump0), 0);
      chk("chk_err", 32'(chk_err), 1);
`else
      chk("nochk_v0", 32'(upd_valid0), 1);
      chk("nochk_pc0", upd_pc0, 32'h100);
      chk("nochk_err", 32'(chk_err), 0);
`endif
      chk("chk_count", 32'(count), 0);
      step();
      chk("chk_err_end", 32'(chk_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
